serial_adder_ctrl: RTL and testbench

Bit-serial adder controller for the ripple-carry adder lab datapath. It sequences one full-adder cell, built from two half adders and an OR gate, over WIDTH cycles, so an N-bit add costs N cycles instead of N adder slices. A start/busy/done handshake faces the requester. Sum and carry-out appear in registers that hold until the next operation completes.

---
 rtl/adder_pkg.sv | 12 +
 rtl/half_adder.sv | 13 +
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encodings and width limit.
package adder_pkg;

    localparam int unsigned ADDER_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// Gate-level half adder.
// Ports: a, b - addends; s - sum bit; c - carry bit.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    xor g_xor (s, a, b);
    and g_and (c, a, b);

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell: two half adders plus an OR for the carry.
// Ports: x, y - operand bits; ci - carry in; s - sum bit; co - carry out.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(x),  .b(y),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    or g_or (co, c0, c1);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles
// behind a start/busy/done handshake.
// Ports: clk, rst_n (async active-low); start, a, b, cin - request and operands;
//        busy - high while adding; done - one-cycle completion pulse;
//        sum, cout - result registers, updated only on completion.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > ADDER_MAX_W) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t             state,  state_d;
    logic [WIDTH-1:0]   sa,     sa_d;
    logic [WIDTH-1:0]   sb,     sb_d;
    logic [WIDTH-1:0]   acc,    acc_d;
    logic               carry,  carry_d;
    logic [CNT_W-1:0]   cnt,    cnt_d;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d;
    logic               busy_d;
    logic               done_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH:0]     acc_ext;

    // Single shared full-adder cell working on the LSBs of the shift registers.
    serial_fa_cell u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; the slice form also holds for WIDTH=1.
    assign acc_ext = {fa_s, acc};

    // Next-state and datapath update.
    always_comb begin
        state_d = state;
        sa_d    = sa;
        sb_d    = sb;
        acc_d   = acc;
        carry_d = carry;
        cnt_d   = cnt;
        sum_d   = sum;
        cout_d  = cout;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = acc_ext[WIDTH:1];
                sa_d    = sa >> 1;
                sb_d    = sb >> 1;
                carry_d = fa_co;
                cnt_d   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    sum_d   = acc_ext[WIDTH:1];
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flops follow the state they will sit beside.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            sa    <= sa_d;
            sb    <= sb_d;
            acc   <= acc_d;
            carry <= carry_d;
            cnt   <= cnt_d;
            sum   <= sum_d;
            cout  <= cout_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH 8, 1 and 32.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;

    logic        start1, cin1, busy1, done1, cout1;
    logic [0:0]  a1, b1, sum1;

    logic        start32, cin32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder_ctrl #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 add and check latency, result and done pulse width.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string tag);
        int n;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk({tag, " busy_on_accept"}, 64'(busy8), 64'd1);
        n = 0;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd8);
        chk({tag, " sum"}, 64'(sum8), 64'(es));
        chk({tag, " cout"}, 64'(cout8), 64'(ec));
        chk({tag, " busy_in_done"}, 64'(busy8), 64'd0);
        step();
        chk({tag, " done_one_cycle"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int n;
        int m;
        logic [32:0] ref32;
        logic [1:0]  ref1;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;

        // Reset state
        #12;
        chk("rst busy", 64'(busy8), 64'd0);
        chk("rst done", 64'(done8), 64'd0);
        chk("rst sum", 64'(sum8), 64'd0);
        chk("rst cout", 64'(cout8), 64'd0);
        chk("rst busy32", 64'(busy32), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 0x3C + 0x5A with per-cycle checks
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        chk("3c5a busy_k", 64'(busy8), 64'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("3c5a busy_k+%0d", i), 64'(busy8), 64'd1);
            chk($sformatf("3c5a done_k+%0d", i), 64'(done8), 64'd0);
            chk($sformatf("3c5a sum_hold_k+%0d", i), 64'(sum8), 64'd0);
        end
        step();
        chk("3c5a done_k+8", 64'(done8), 64'd1);
        chk("3c5a busy_k+8", 64'(busy8), 64'd0);
        chk("3c5a sum", 64'(sum8), 64'h96);
        chk("3c5a cout", 64'(cout8), 64'd0);
        step();
        chk("3c5a done_k+9", 64'(done8), 64'd0);
        chk("3c5a sum_hold_idle", 64'(sum8), 64'h96);

        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff01");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ffff1");

        // start re-asserted in RUN cycle 3 with other operands is ignored
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 3;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        chk("ignore latency", 64'(n), 64'd8);
        chk("ignore sum", 64'(sum8), 64'h34);
        chk("ignore cout", 64'(cout8), 64'd0);
        step();
        chk("ignore done_once", 64'(done8), 64'd0);
        chk("ignore no_restart", 64'(busy8), 64'd0);
        step();
        chk("ignore done_stays_low", 64'(done8), 64'd0);

        // Reset in RUN cycle 4 clears outputs immediately
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy8), 64'd0);
        chk("midrst done", 64'(done8), 64'd0);
        chk("midrst sum", 64'(sum8), 64'd0);
        chk("midrst cout", 64'(cout8), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst stays_idle", 64'(busy8), 64'd0);
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "post_rst");

        // Back-to-back: start held through DONE
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        a8 = 8'h80; b8 = 8'h80;
        n = 0;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        chk("b2b first latency", 64'(n), 64'd8);
        chk("b2b first sum", 64'(sum8), 64'h30);
        chk("b2b first cout", 64'(cout8), 64'd0);
        chk("b2b busy_drops", 64'(busy8), 64'd0);
        step();
        start8 = 1'b0;
        chk("b2b second accepted", 64'(busy8), 64'd1);
        chk("b2b done_low", 64'(done8), 64'd0);
        chk("b2b sum_hold", 64'(sum8), 64'h30);
        m = 1;
        while (!done8 && m < 40) begin
            step();
            m++;
        end
        chk("b2b done_spacing", 64'(m), 64'd9);
        chk("b2b second sum", 64'(sum8), 64'h00);
        chk("b2b second cout", 64'(cout8), 64'd1);
        step();
        chk("b2b done_low_after", 64'(done8), 64'd0);

        // Random WIDTH=1
        for (int i = 0; i < 500; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            ref1 = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            n = 0;
            while (!done1 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("w1 op%0d {latency,cout,sum}", i),
                {32'(n), 30'd0, cout1, sum1}, {32'd1, 30'd0, ref1});
        end

        // Random WIDTH=32
        for (int i = 0; i < 500; i++) begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (i == 0) begin
                a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0000; cin32 = 1'b1;
            end
            ref32 = 33'(a32) + 33'(b32) + 33'(cin32);
            start32 = 1'b1;
            step();
            start32 = 1'b0;
            a32 = $urandom; b32 = $urandom;
            n = 0;
            while (!done32 && n < 60) begin
                step();
                n++;
            end
            chk($sformatf("w32 op%0d {latency,cout,sum}", i),
                {24'(n), 7'd0, cout32, sum32}, {24'd32, 7'd0, ref32});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
